// File: rtl/cla8_sub_pipe_if.sv
// Operand/result handshake bundle for the two-stage 8-bit lookahead subtractor.
// master is the surrounding environment; slave is the subtractor itself.
interface cla8_sub_pipe_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       borrow_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       borrow_out;
   logic       overflow;
   logic       zero;

   modport master (
      output in_valid, a, b, borrow_in, out_ready,
      input  in_ready, out_valid, diff, borrow_out, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, borrow_in, out_ready,
      output in_ready, out_valid, diff, borrow_out, overflow, zero
   );
endinterface

// File: rtl/cla8_sub_pipe.sv
// Two-stage pipelined 8-bit subtractor: a - b - borrow_in computed as a + ~b + ~borrow_in
// with a carry-lookahead chain; stage 1 holds bit/group g,p, stage 2 resolves carries.
module cla8_sub_pipe (
   input  logic            clk,
   input  logic            rst_n,
   cla8_sub_pipe_if.slave  bus
);

   function automatic logic [3:0] nib_carry(input logic [3:0] g, input logic [3:0] p,
                                            input logic cin);
      logic [3:0] c;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      return c;
   endfunction

   function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   logic [7:0] nb;
   logic [7:0] g_in;
   logic [7:0] p_in;

   logic [7:0] s1_g;
   logic [7:0] s1_p;
   logic [1:0] s1_gg;
   logic [1:0] s1_pg;
   logic       s1_c0;
   logic       s1_a7;
   logic       s1_nb7;
   logic       s1_v;

   logic [7:0] diff_q;
   logic       borrow_q;
   logic       ovf_q;
   logic       zero_q;
   logic       s2_v;

   logic       adv1;
   logic       adv2;
   logic       c4;
   logic       c8;
   logic [7:0] carries;
   logic [7:0] diff_nx;

   assign nb   = ~bus.b;
   assign g_in = bus.a & nb;
   assign p_in = bus.a ^ nb;

   assign adv2 = ~s2_v | bus.out_ready;
   assign adv1 = ~s1_v | adv2;

   assign c4      = s1_gg[0] | (s1_pg[0] & s1_c0);
   assign c8      = s1_gg[1] | (s1_pg[1] & s1_gg[0]) | (s1_pg[1] & s1_pg[0] & s1_c0);
   assign carries = {nib_carry(s1_g[7:4], s1_p[7:4], c4), nib_carry(s1_g[3:0], s1_p[3:0], s1_c0)};
   assign diff_nx = s1_p ^ carries;

   // Data registers only move with a valid entry, so an idle pipeline keeps its last values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v     <= 1'b0;
         s1_g     <= '0;
         s1_p     <= '0;
         s1_gg    <= '0;
         s1_pg    <= '0;
         s1_c0    <= 1'b0;
         s1_a7    <= 1'b0;
         s1_nb7   <= 1'b0;
         s2_v     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         if (adv1) begin
            s1_v <= bus.in_valid;
            if (bus.in_valid) begin
               s1_g     <= g_in;
               s1_p     <= p_in;
               s1_gg[0] <= grp_gen(g_in[3:0], p_in[3:0]);
               s1_gg[1] <= grp_gen(g_in[7:4], p_in[7:4]);
               s1_pg[0] <= &p_in[3:0];
               s1_pg[1] <= &p_in[7:4];
               s1_c0    <= ~bus.borrow_in;
               s1_a7    <= bus.a[7];
               s1_nb7   <= nb[7];
            end
         end
         if (adv2) begin
            s2_v <= s1_v;
            if (s1_v) begin
               diff_q   <= diff_nx;
               borrow_q <= ~c8;
               ovf_q    <= (s1_a7 == s1_nb7) & (diff_nx[7] != s1_a7);
               zero_q   <= (diff_nx == 8'h00);
            end
         end
      end
   end

   assign bus.in_ready   = adv1;
   assign bus.out_valid  = s2_v;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;
   assign bus.overflow   = ovf_q;
   assign bus.zero       = zero_q;

endmodule

// File: tb/tb_cla8_sub_pipe.sv
// Bench for cla8_sub_pipe: directed vector table, backpressure and reset sequences,
// then a randomized handshake run scored against an arithmetic reference queue.
module tb_cla8_sub_pipe;

   typedef struct packed {
      logic [7:0] d;
      logic       bo;
      logic       ov;
      logic       z;
   } res_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      res_t       exp;
   } vec_t;

   logic clk;
   logic rst_n;
   cla8_sub_pipe_if bus();

   cla8_sub_pipe dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   res_t q[$];
   logic hold_pend = 1'b0;
   res_t hold_val;

   function automatic res_t ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
      res_t r;
      int u;
      int s;
      u    = int'(a) - int'(b) - int'(bin);
      s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
      r.d  = u[7:0];
      r.bo = (u < 0);
      r.ov = (s < -128) || (s > 127);
      r.z  = (u == 0) || (u == -256);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic res_t out_now();
      return {bus.diff, bus.borrow_out, bus.overflow, bus.zero};
   endfunction

   // One clock: check in_ready and hold behaviour, then score any transfers on the edge.
   task automatic cyc(output logic fin);
      res_t got;
      res_t exp;
      logic fout;
      res_t pushed;
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(!(q.size() == 2 && !bus.out_ready)));
      got = out_now();
      if (hold_pend) chk("hold", 32'({bus.out_valid, got}), 32'({1'b1, hold_val}));
      fin       = bus.in_valid & bus.in_ready;
      fout      = bus.out_valid & bus.out_ready;
      hold_pend = bus.out_valid & !bus.out_ready;
      hold_val  = got;
      pushed    = ref_sub(bus.a, bus.b, bus.borrow_in);
      @(posedge clk);
      #1;
      if (fout) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out: got diff %0h with no pending op at %0t", got.d, $time);
         end else begin
            exp = q.pop_front();
            chk("result", 32'(got), 32'(exp));
         end
      end
      if (fin) q.push_back(pushed);
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
      bus.in_valid  = v;
      bus.a         = a;
      bus.b         = b;
      bus.borrow_in = bin;
   endtask

   task automatic chk_out(input string name, input logic v, input res_t r);
      chk(name, 32'({bus.out_valid, out_now()}), 32'({v, r}));
   endtask

   vec_t vecs[8];
   logic fin;
   int   sent;
   int   ncyc;

   initial begin
      vecs[0] = '{8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0, 1'b0}};
      vecs[1] = '{8'h00, 8'h01, 1'b0, '{8'hFF, 1'b1, 1'b0, 1'b0}};
      vecs[2] = '{8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1, 1'b0}};
      vecs[3] = '{8'h10, 8'h0F, 1'b1, '{8'h00, 1'b0, 1'b0, 1'b1}};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b0}};
      vecs[5] = '{8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b1, 1'b1, 1'b0}};
      vecs[6] = '{8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b1}};
      vecs[7] = '{8'h80, 8'h7F, 1'b0, '{8'h01, 1'b0, 1'b1, 1'b0}};

      rst_n = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      bus.out_ready = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk_out("rst_out", 1'b0, '0);
      #11 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors: exact 2-cycle latency and flags
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin);
         cyc(fin);
         chk($sformatf("vec%0d_accept", i), 32'(fin), 32'd1);
         drive(1'b0, 8'h00, 8'h00, 1'b0);
         chk($sformatf("vec%0d_lat1", i), 32'(bus.out_valid), 32'd0);
         cyc(fin);
         chk_out($sformatf("vec%0d_out", i), 1'b1, vecs[i].exp);
         cyc(fin);
      end

      // Backpressure: two accepts fill the pipe, the third waits, results drain in order
      bus.out_ready = 1'b0;
      drive(1'b1, 8'h20, 8'h01, 1'b0);
      cyc(fin);
      chk("bp_acc0", 32'(fin), 32'd1);
      drive(1'b1, 8'h30, 8'h31, 1'b0);
      cyc(fin);
      chk("bp_acc1", 32'(fin), 32'd1);
      drive(1'b1, 8'h44, 8'h40, 1'b1);
      chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
      chk_out("bp_head", 1'b1, '{8'h1F, 1'b0, 1'b0, 1'b0});
      cyc(fin);
      cyc(fin);
      chk("bp_no_accept", 32'(fin), 32'd0);
      chk_out("bp_hold", 1'b1, '{8'h1F, 1'b0, 1'b0, 1'b0});
      bus.out_ready = 1'b1;
      cyc(fin);
      chk("bp_acc2", 32'(fin), 32'd1);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      chk_out("bp_out1", 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b0});
      cyc(fin);
      chk_out("bp_out2", 1'b1, '{8'h03, 1'b0, 1'b0, 1'b0});
      cyc(fin);
      chk("bp_empty", 32'(bus.out_valid), 32'd0);
      chk("bp_queue", 32'(q.size()), 32'd0);

      // Asynchronous reset with both stages full
      bus.out_ready = 1'b0;
      drive(1'b1, 8'h99, 8'h11, 1'b0);
      cyc(fin);
      drive(1'b1, 8'h01, 8'h02, 1'b0);
      cyc(fin);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      chk("rs_full", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_out("rs_clear", 1'b0, '0);
      chk("rs_in_ready", 32'(bus.in_ready), 32'd1);
      q.delete();
      hold_pend = 1'b0;
      #2 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b1, 8'h05, 8'h06, 1'b0);
      cyc(fin);
      chk("rs_first_accept", 32'(fin), 32'd1);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      chk("rs_lat1", 32'(bus.out_valid), 32'd0);
      cyc(fin);
      chk_out("rs_out", 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < 3; i++) begin
         cyc(fin);
         chk("rs_no_stale", 32'(bus.out_valid), 32'd0);
      end

      // Random traffic against the reference queue
      sent = 0;
      ncyc = 0;
      while (sent < 10000 && ncyc < 60000) begin
         drive($urandom_range(0, 99) < 70, 8'($urandom), 8'($urandom), 1'($urandom));
         bus.out_ready = ($urandom_range(0, 99) < 70);
         cyc(fin);
         if (fin) sent++;
         ncyc++;
      end
      chk("rand_sent", 32'(sent), 32'd10000);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10 && q.size() > 0; i++) cyc(fin);
      chk("rand_drain", 32'(q.size()), 32'd0);
      cyc(fin);
      chk("rand_idle", 32'(bus.out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cla8_sub_pipe.md
CLA8_SUB_PIPE -- requirements
Module: cla8_sub_pipe

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 8 bits.
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  the operand set on a, b and borrow_in is valid.
REQ-005 in_ready  output  1  the block accepts an operand set this cycle.
REQ-006 a  input  8  minuend.
REQ-007 b  input  8  subtrahend.
REQ-008 borrow_in  input  1  borrow into bit 0.
REQ-009 out_valid  output  1  the result fields are valid.
REQ-010 out_ready  input  1  the downstream consumer accepts the result this cycle.
REQ-011 diff  output  8  result of a - b - borrow_in, modulo 256.
REQ-012 borrow_out  output  1  borrow out of bit 7 (unsigned a < b + borrow_in).
REQ-013 overflow  output  1  signed two's-complement overflow of the subtraction.
REQ-014 zero  output  1  diff equals 0x00.

Function
REQ-015 The subtraction SHALL be computed as a + ~b + c0, with c0 = ~borrow_in and borrow_out = ~c8.
REQ-016 The carry chain SHALL be carry-lookahead, using per-bit g = a & ~b and p = a ^ ~b, and 4-bit group generate/propagate signals; no ripple chain longer than 4 bits is allowed.
REQ-017 Stage 1 SHALL register the per-bit p and g, the group G/P for both nibbles, c0 and a[7]/~b[7], together with a valid bit s1_v.
REQ-018 Stage 2 SHALL resolve c4 = G0 | P0&c0 and c8 = G1 | P1&G0 | P1&P0&c0, form diff = p ^ {c7..c0}, and register diff, borrow_out, overflow, zero and s2_v.
REQ-019 Latency SHALL be exactly 2 cycles from an accepting edge (in_valid & in_ready) to out_valid, when there is no backpressure.
REQ-020 Throughput SHALL be one operation per cycle while out_ready is high.
REQ-021 out_valid SHALL equal s2_v, and the result outputs SHALL be driven directly from the stage-2 registers.
REQ-022 Stage 2 SHALL load when !s2_v or out_ready (adv2); s2_v SHALL then take the value of s1_v.
REQ-023 Stage 1 SHALL load when !s1_v or adv2 (adv1); s1_v SHALL then take the value of in_valid.
REQ-024 in_ready SHALL equal adv1, combinationally; there is no path from in_valid to in_ready.
REQ-025 While out_valid & !out_ready, diff, borrow_out, overflow and zero SHALL hold stable, and no data SHALL be lost or duplicated.
REQ-026 Two operations SHALL be held at most, one per stage; with both stages full and out_ready low, in_ready SHALL be low.
REQ-027 When in_valid and out_ready are both asserted while both stages are full, the block SHALL accept one input and emit one output in the same cycle.
REQ-028 overflow SHALL be 1 exactly when a[7] != b[7] and diff[7] != a[7].
REQ-029 When no entry is loaded, the stage data registers SHALL hold their value; only the valid bits gate correctness.

Reset
REQ-030 Asserting rst_n low SHALL, asynchronously, clear s1_v, s2_v, diff, borrow_out, overflow and zero to 0, even mid-operation and with in-flight data discarded.
REQ-031 During reset, in_ready SHALL read 1 and out_valid SHALL read 0.
REQ-032 After rst_n deasserts, the first edge SHALL accept input normally.

Verification
REQ-033 The bench SHALL drive a=0x05, b=0x03, borrow_in=0 with out_ready=1 -> out_valid 2 cycles later with diff=0x02, borrow_out=0, overflow=0, zero=0.
REQ-034 The bench SHALL drive a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1, overflow=0, zero=0; then a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0.
REQ-035 The bench SHALL drive a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, zero=1, borrow_out=0.
REQ-036 The bench SHALL stream 3 back-to-back ops with out_ready=0 -> in_ready drops after 2 accepts, outputs hold; then raise out_ready -> results emerge in order, one per cycle, with none lost.
REQ-037 The bench SHALL pulse rst_n low asynchronously between edges with both stages full -> out_valid and all outputs go to 0 immediately, and no stale result appears after release.
REQ-038 The bench SHALL run 10k random ops with random in_valid/out_ready -> every result matches a reference model of (a - b - borrow_in) mod 256 and its flags, in order.
